// File: rtl/selsplit_2_drv.sv
// Clocked driver into a 2-way self-timed split: one word in flight, drive pulse out, free pulse back.
// Latency: data/valid one cycle after accept, drive after SETUP_CYCLES, idle 2-3 cycles after free.
// Backpressure: s_ready only in IDLE. Optional watchdog: SELSPLIT_2_DRV_TIMEOUT_EN.
module selsplit_2_drv #(
  parameter int DATA_WIDTH     = 32,
  parameter int SETUP_CYCLES   = 1,
  parameter int DRIVE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [1:0]            s_dest,
  output logic                  o_drive,
  output logic                  o_valid0,
  output logic                  o_valid1,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_free,
  output logic                  o_busy,
  output logic [15:0]           o_txn_cnt,
  output logic                  o_err_spurious
`ifdef SELSPLIT_2_DRV_TIMEOUT_EN
  , output logic                o_timeout
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, WAIT_FREE} state_t;

  state_t      state;
  logic [15:0] phaseCnt;
  logic        freeMeta, freeSync, freeDly, freePend;
  logic        freeEvt;
  logic        accept;

  assign freeEvt = freeSync & ~freeDly;
  assign s_ready = (state == IDLE);
  assign accept  = s_valid & s_ready;
  assign o_busy  = (state != IDLE);

  // i_free comes from the self-timed domain
  always_ff @(posedge clk) begin
    if (rst) begin
      freeMeta <= 1'b0;
      freeSync <= 1'b0;
      freeDly  <= 1'b0;
    end else begin
      freeMeta <= i_free;
      freeSync <= freeMeta;
      freeDly  <= freeSync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      phaseCnt       <= 16'd0;
      freePend       <= 1'b0;
      o_drive        <= 1'b0;
      o_valid0       <= 1'b0;
      o_valid1       <= 1'b0;
      o_data         <= '0;
      o_txn_cnt      <= 16'd0;
      o_err_spurious <= 1'b0;
`ifdef SELSPLIT_2_DRV_TIMEOUT_EN
      o_timeout      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (freeEvt) o_err_spurious <= 1'b1;
          // an all-zero mask is consumed without touching the split stage
          if (accept && s_dest != 2'b00) begin
            o_data   <= s_data;
            o_valid0 <= s_dest[0];
            o_valid1 <= s_dest[1];
            phaseCnt <= 16'd0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (freeEvt) o_err_spurious <= 1'b1;
          if (phaseCnt == 16'(SETUP_CYCLES - 1)) begin
            phaseCnt <= 16'd0;
            o_drive  <= 1'b1;
            state    <= DRIVE;
          end else begin
            phaseCnt <= phaseCnt + 16'd1;
          end
        end
        DRIVE: begin
          // a fast split stage can answer before the drive pulse ends
          if (freeEvt) begin
            if (freePend) o_err_spurious <= 1'b1;
            freePend <= 1'b1;
          end
          if (phaseCnt == 16'(DRIVE_CYCLES - 1)) begin
            phaseCnt <= 16'd0;
            o_drive  <= 1'b0;
            state    <= WAIT_FREE;
          end else begin
            phaseCnt <= phaseCnt + 16'd1;
          end
        end
        WAIT_FREE: begin
          if (freeEvt && freePend) o_err_spurious <= 1'b1;
          if (freeEvt || freePend) begin
            o_txn_cnt <= o_txn_cnt + 16'd1;
            freePend  <= 1'b0;
            o_valid0  <= 1'b0;
            o_valid1  <= 1'b0;
            state     <= IDLE;
          end
`ifdef SELSPLIT_2_DRV_TIMEOUT_EN
          else if (phaseCnt == 16'(TIMEOUT_CYCLES - 1)) begin
            o_timeout <= 1'b1;
            o_valid0  <= 1'b0;
            o_valid1  <= 1'b0;
            state     <= IDLE;
          end else begin
            phaseCnt <= phaseCnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selsplit_2_drv.sv
// Randomized bench for selsplit_2_drv against a transaction-level expectation model.
module tb_selsplit_2_drv;
  localparam int DW    = 32;
  localparam int SETUP = 1;
  localparam int DRIVE = 2;
  localparam int TOUT  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [1:0]    s_dest;
  logic          o_drive, o_valid0, o_valid1, i_free, o_busy, o_err_spurious;
  logic [DW-1:0] o_data;
  logic [15:0]   o_txn_cnt;
`ifdef SELSPLIT_2_DRV_TIMEOUT_EN
  logic          o_timeout;
`endif

  selsplit_2_drv #(
    .DATA_WIDTH(DW), .SETUP_CYCLES(SETUP), .DRIVE_CYCLES(DRIVE), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dest(s_dest), .o_drive(o_drive), .o_valid0(o_valid0), .o_valid1(o_valid1),
    .o_data(o_data), .i_free(i_free), .o_busy(o_busy), .o_txn_cnt(o_txn_cnt),
    .o_err_spurious(o_err_spurious)
`ifdef SELSPLIT_2_DRV_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [15:0] expTxn  = 16'd0;
  logic        expErr  = 1'b0;
  logic [DW-1:0] lastData = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulseFree();
    i_free = 1'b1;
    repeat (2) @(negedge clk);
    i_free = 1'b0;
  endtask

  // mode 0: free returned 'delay' cycles after drive falls; 1: free during drive; 2: no free
  task automatic send(input logic [DW-1:0] d, input logic [1:0] dest, input int mode, input int delay);
    int n, w, m;
    bit stable;
    s_valid = 1'b1; s_data = d; s_dest = dest;
    chk("ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    if (dest == 2'b00) begin
      chk("drop_busy", o_busy, 0);
      chk("drop_data", o_data, lastData);
      chk("drop_valid", {o_valid1, o_valid0}, 0);
      n = 0;
      repeat (4) begin @(negedge clk); n += o_drive; end
      chk("drop_drive", n, 0);
      chk("drop_txn", o_txn_cnt, expTxn);
      return;
    end
    chk("acc_data", o_data, d);
    chk("acc_valid", {o_valid1, o_valid0}, dest);
    chk("acc_drive", o_drive, 0);
    if (mode == 1) fork pulseFree(); join_none
    n = 0;
    while (!o_drive && n < 20) begin @(negedge clk); n++; end
    chk("setup_len", n, SETUP);
    w = 0; stable = 1'b1;
    while (o_drive && w < 20) begin
      if (o_data !== d || {o_valid1, o_valid0} !== dest) stable = 1'b0;
      @(negedge clk); w++;
    end
    chk("drive_len", w, DRIVE);
    lastData = d;
    if (mode == 2) return;
    if (mode == 0) begin
      repeat (delay) begin
        if (o_data !== d || {o_valid1, o_valid0} !== dest || !o_busy) stable = 1'b0;
        @(negedge clk);
      end
      fork pulseFree(); join_none
    end
    m = 0;
    while (o_busy && m < 20) begin
      if (o_data !== d || {o_valid1, o_valid0} !== dest) stable = 1'b0;
      @(negedge clk); m++;
    end
    if (mode == 1) chk("early_ret", m, 1);
    else chk("free_lat_ok", (m >= 2 && m <= 3), 1);
    chk("stable", stable, 1);
    expTxn = expTxn + 16'd1;
    chk("txn", o_txn_cnt, expTxn);
    chk("end_valid", {o_valid1, o_valid0}, 0);
    chk("end_data", o_data, d);
    chk("err", o_err_spurious, expErr);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int m;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_dest = 2'b00; i_free = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", s_ready, 1);
    chk("rst_outs", {o_drive, o_valid1, o_valid0, o_busy, o_err_spurious}, 0);
    chk("rst_data", o_data, 0);
    chk("rst_txn", o_txn_cnt, 0);

    send(32'hDEADBEEF, 2'b01, 0, 5);
    send(32'h12345678, 2'b11, 0, 3);
    send(32'hCAFEF00D, 2'b10, 1, 0);
    send(32'h0BADBEEF, 2'b00, 0, 0);

    fork pulseFree(); join_none
    repeat (6) @(negedge clk);
    expErr = 1'b1;
    chk("idle_spur_err", o_err_spurious, 1);
    chk("idle_spur_busy", o_busy, 0);
    chk("idle_spur_txn", o_txn_cnt, expTxn);

    for (int i = 0; i < 25; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 1 : 0,
           $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("sticky_err", o_err_spurious, expErr);

    // abort in WAIT_FREE, then a late free is spurious
    send(32'hA5A5A5A5, 2'b11, 2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expTxn = 16'd0; expErr = 1'b0;
    chk("midrst_outs", {o_drive, o_valid1, o_valid0, o_busy, o_err_spurious}, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_txn", o_txn_cnt, expTxn);
    lastData = '0;
    fork pulseFree(); join_none
    repeat (6) @(negedge clk);
    expErr = 1'b1;
    chk("late_free_err", o_err_spurious, 1);
    chk("late_free_busy", o_busy, 0);

`ifdef SELSPLIT_2_DRV_TIMEOUT_EN
    chk("tout_init", o_timeout, 0);
    send(32'h5A5A5A5A, 2'b01, 2, 0);
    m = 0;
    while (o_busy && m < 100) begin @(negedge clk); m++; end
    chk("tout_len", m, TOUT);
    chk("tout_flag", o_timeout, 1);
    chk("tout_txn", o_txn_cnt, expTxn);
    chk("tout_valid", {o_valid1, o_valid0}, 0);
`else
    m = 0;
`endif
    send(32'h0F0F0F0F, 2'b10, 0, 2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/selsplit_2_drv.md
Name: selsplit_2_drv

Overview:
Clocked upstream driver for the 2-way conditional split stage (drive/free click handshake with per-branch valid and shared data).
- Accepts words from a synchronous valid/ready stream, each carrying a 2-bit destination mask.
- Presents data and valid bits, issues a drive pulse, then holds everything stable until the split stage's free pulse returns.
- Bridges the clocked control fabric into the self-timed split network; exactly one transaction is in flight at a time.

Parameters:
DATA_WIDTH, 32, width of s_data / o_data
SETUP_CYCLES, 1, cycles o_data/o_valid0/o_valid1 are stable before o_drive rises (min 1)
DRIVE_CYCLES, 2, cycles o_drive is held high (min 1)
TIMEOUT_CYCLES, 1024, WAIT_FREE watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_valid  in  1  upstream word valid
s_ready  out  1  block can accept a word
s_data  in  DATA_WIDTH  upstream data
s_dest  in  2  destination mask; bit0 = branch 0, bit1 = branch 1
o_drive  out  1  drive pulse to split stage (i_drive)
o_valid0  out  1  branch-0 select (valid0)
o_valid1  out  1  branch-1 select (valid1)
o_data  out  DATA_WIDTH  data to split stage (i_data)
i_free  in  1  free pulse from split stage (o_free), asynchronous to clk
o_busy  out  1  transaction in flight (state != IDLE)
o_txn_cnt  out  16  completed transactions (free received); wraps 0xFFFF -> 0
o_err_spurious  out  1  sticky: free edge seen while not expecting one

Behaviour:
- Reset: synchronous, active-high, takes priority over everything.
  - State = IDLE; s_ready = 1 after reset deasserts.
  - o_drive = 0, o_valid0 = 0, o_valid1 = 0, o_data = 0.
  - o_busy = 0, o_txn_cnt = 0, o_err_spurious = 0; synchronizer flops cleared.
- Reset asserted mid-transaction aborts it. No free is awaited. A late free arriving after reset sets o_err_spurious.
- i_free handling: 2-flop synchronizer, then a rising-edge detector producing free_evt (1 cycle).
  - Free pulse width must be at least 1 clk period.
  - Latency from i_free edge to free_evt: 2–3 cycles.
- s_ready = (state == IDLE). A word is accepted when s_valid & s_ready.
- State machine:
  - IDLE: on accept with s_dest != 0, register s_data into o_data and s_dest into o_valid1/o_valid0, clear counter, go to SETUP. On accept with s_dest == 0, consume the word with no drive and no output change; stay IDLE.
  - SETUP: count SETUP_CYCLES, then go to DRIVE.
  - DRIVE: o_drive = 1 for exactly DRIVE_CYCLES cycles, then go to WAIT_FREE. A free_evt arriving during DRIVE is latched (free_pend) and honoured on entry to WAIT_FREE.
  - WAIT_FREE: on free_evt or free_pend, increment o_txn_cnt, clear free_pend, clear o_valid0/o_valid1, go to IDLE. o_data keeps its last value.
- o_data and o_valid* must not change from SETUP entry until WAIT_FREE exit.
- Minimum accept-to-accept spacing = 1 + SETUP_CYCLES + DRIVE_CYCLES + free latency.
- Spurious events: a free_evt in IDLE or SETUP sets o_err_spurious (sticky until rst). It is otherwise ignored and causes no state change. A second free_evt in DRIVE while free_pend is already set also sets o_err_spurious.
- Counter: only o_txn_cnt counts transactions; each counts once. s_dest == 0 words are not counted.

Optional Feature:
Macro SELSPLIT_2_DRV_TIMEOUT_EN.
- Defined:
  - Add output o_timeout (1 bit, sticky, reset 0).
  - A 16-bit watchdog counts cycles in WAIT_FREE. On reaching TIMEOUT_CYCLES: set o_timeout, clear o_valid*, return to IDLE without incrementing o_txn_cnt.
  - A free arriving later is treated as spurious.
- Not defined: no o_timeout port and no watchdog logic; WAIT_FREE waits indefinitely.

Test Plan:
1. Reset, then check the idle state. Hold rst 3 cycles, release -> s_ready=1, all outputs 0, o_txn_cnt=0.
2. Single branch-0 word. Send s_data=0xDEADBEEF, s_dest=2'b01. Return an i_free pulse 5 cycles after o_drive falls. Required:
   - o_data=0xDEADBEEF and o_valid0=1/o_valid1=0 one cycle after accept.
   - o_drive high exactly 2 cycles, starting SETUP_CYCLES after that.
   - Back to IDLE 2–3 cycles after i_free; o_txn_cnt=1.
3. Broadcast word. Send s_dest=2'b11, s_data=0x12345678 -> o_valid0=o_valid1=1 throughout; o_data stable until free; o_txn_cnt increments by 1.
4. Early free. Pulse i_free during DRIVE -> free_pend set; block returns to IDLE on the first WAIT_FREE cycle; o_err_spurious=0.
5. Drop and spurious free:
   - s_dest=2'b00 word -> consumed in 1 cycle, o_drive never rises, o_txn_cnt unchanged.
   - i_free pulse while IDLE -> o_err_spurious=1 and stays 1.
6. Reset mid-flight, and timeout (macro defined, TIMEOUT_CYCLES=16):
   - Assert rst in WAIT_FREE -> all outputs 0 next cycle.
   - Separately, withhold i_free -> o_timeout=1 after 16 WAIT_FREE cycles, then IDLE, o_txn_cnt unchanged.
